// File: rtl/inv_shift_rows_seq.sv
// AES InvShiftRows as a handshaked block: one row rotated per cycle (ROW_SERIAL=1)
// or the whole state in a single cycle (ROW_SERIAL=0), result held until taken.
module inv_shift_rows_seq #(
    parameter int ROW_SERIAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] Input,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Output,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        ROW1,
        ROW2,
        ROW3,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  data_q, data_d;

    // row_rot[r] is data_q with only row r rotated right by r columns
    logic [3:1][127:0] row_rot;
    logic [127:0]      full_shift;

    genvar gi, gr;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_full
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C - R + 4) % 4) + R;
            assign full_shift[127-8*gi -: 8] = Input[127-8*SRC -: 8];
        end
        for (gr = 1; gr < 4; gr++) begin : g_row
            for (gi = 0; gi < 16; gi++) begin : g_byte
                localparam int R   = gi % 4;
                localparam int C   = gi / 4;
                localparam int SRC = (R == gr) ? 4 * ((C - R + 4) % 4) + R : gi;
                assign row_rot[gr][127-8*gi -: 8] = data_q[127-8*SRC -: 8];
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    if (ROW_SERIAL != 0) begin
                        data_d  = Input;
                        state_d = ROW1;
                    end else begin
                        data_d  = full_shift;
                        state_d = DONE;
                    end
                end
            end
            ROW1: begin
                data_d  = row_rot[1];
                state_d = ROW2;
            end
            ROW2: begin
                data_d  = row_rot[2];
                state_d = ROW3;
            end
            ROW3: begin
                data_d  = row_rot[3];
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign Output = data_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Bench for inv_shift_rows_seq: serial and parallel instances checked every cycle
// against a transaction-level model, plus directed literal vectors.
module tb_inv_shift_rows_seq;

    logic              clk;
    logic              rst;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [1:0]        busy;
    logic [1:0][127:0] din;
    logic [1:0][127:0] dout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // index 0: ROW_SERIAL=1, index 1: ROW_SERIAL=0
    inv_shift_rows_seq #(.ROW_SERIAL(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Input(din[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .Output(dout[0]), .busy(busy[0])
    );
    inv_shift_rows_seq #(.ROW_SERIAL(0)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Input(din[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .Output(dout[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] inv_shift(input logic [127:0] x);
        logic [7:0]   m [4][4];
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = x[127-8*(4*c+r) -: 8];
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = m[r][(c - r + 4) % 4];
        return y;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Transaction model: idle / waiting m_cnt cycles / holding a result
    bit           m_idle  [2] = '{1'b1, 1'b1};
    bit           m_valid [2] = '{1'b0, 1'b0};
    int           m_cnt   [2] = '{0, 0};
    logic [127:0] m_exp   [2] = '{128'h0, 128'h0};
    logic [127:0] m_data  [2] = '{128'h0, 128'h0};
    int           acc_q0[$];
    int           acc_q1[$];

    initial forever begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_idle[k]  = 1'b1;
                m_valid[k] = 1'b0;
                m_cnt[k]   = 0;
                m_data[k]  = '0;
            end else if (m_idle[k]) begin
                if (in_valid[k]) begin
                    m_idle[k] = 1'b0;
                    m_exp[k]  = inv_shift(din[k]);
                    m_cnt[k]  = lat(k) - 1;
                    if (m_cnt[k] == 0) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = m_exp[k];
                    end
                end
            end else if (!m_valid[k]) begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = m_exp[k];
                end
            end else if (out_ready[k]) begin
                m_valid[k] = 1'b0;
                m_idle[k]  = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("in_ready[%0d] c%0d", k, cyc), in_ready[k], m_idle[k] && !rst);
                chk1($sformatf("out_valid[%0d] c%0d", k, cyc), out_valid[k], m_valid[k]);
                chk1($sformatf("busy[%0d] c%0d", k, cyc), busy[k], !m_idle[k]);
                if (m_idle[k] || m_valid[k])
                    chk($sformatf("Output[%0d] c%0d", k, cyc), dout[k], m_data[k]);
                if (in_valid[k] && in_ready[k]) begin
                    $display("accept dut%0d cycle %0d Input %h", k, cyc, din[k]);
                    if (k == 0) acc_q0.push_back(cyc);
                    else        acc_q1.push_back(cyc);
                end
            end
        end
    end

    // Holds in_valid until the handshake edge, returns 2 time units after it
    task automatic wait_accept(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk1($sformatf("accept_timeout[%0d]", k), ok, 1'b1);
        @(posedge clk);
        #2;
        in_valid[k] = 1'b0;
    endtask

    task automatic run_one(input int k, input logic [127:0] d, input logic [127:0] exp);
        int n;
        bit got;
        @(posedge clk);
        #2;
        din[k]      = d;
        in_valid[k] = 1'b1;
        wait_accept(k);
        got = 1'b0;
        n   = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (out_valid[k]) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        chk1($sformatf("out_timeout[%0d]", k), got, 1'b1);
        if (got) begin
            chk($sformatf("latency[%0d]", k), 128'(n), 128'(lat(k)));
            chk($sformatf("result[%0d]", k), dout[k], exp);
            $display("result dut%0d Input %h Output %h latency %0d", k, d, dout[k], n);
            if (out_ready[k]) begin
                @(negedge clk);
                chk1($sformatf("one_cycle_pulse[%0d]", k), out_valid[k], 1'b0);
            end
        end
    endtask

    localparam logic [127:0] V29_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V29_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V30_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V30_OUT = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] V31     = {4{32'h00112233}};

    initial begin
        int sz;
        bit ok;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        din       = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // pin the model with hand-computed vectors
        chk("model_v29", inv_shift(V29_IN), V29_OUT);
        chk("model_v30", inv_shift(V30_IN), V30_OUT);
        chk("model_v31", inv_shift(V31), V31);

        out_ready = 2'b11;
        run_one(0, V29_IN, V29_OUT);
        run_one(1, V30_IN, V30_OUT);
        run_one(0, V31, V31);
        run_one(1, V31, V31);
        run_one(1, V29_IN, V29_OUT);
        run_one(0, V30_IN, V30_OUT);

        // backpressure: hold result 10 cycles while input side is toggled
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            out_ready[k] = 1'b0;
            din[k]       = V29_IN;
            in_valid[k]  = 1'b1;
            wait_accept(k);
            ok = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid[k]) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk1($sformatf("bp_timeout[%0d]", k), ok, 1'b1);
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #2;
                in_valid[k] = 1'($urandom_range(0, 1));
                din[k]      = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                chk($sformatf("bp_hold[%0d]", k), dout[k], V29_OUT);
                chk1($sformatf("bp_valid[%0d]", k), out_valid[k], 1'b1);
                chk1($sformatf("bp_ready[%0d]", k), in_ready[k], 1'b0);
            end
            @(posedge clk);
            #2;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk1($sformatf("bp_release_ready[%0d]", k), in_ready[k], 1'b1);
            chk1($sformatf("bp_release_valid[%0d]", k), out_valid[k], 1'b0);
        end

        // reset while serial instance sits in ROW2
        @(posedge clk);
        #2;
        din[0]      = V30_IN;
        in_valid[0] = 1'b1;
        wait_accept(0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_output", dout[0], 128'h0);
        chk1("rst_mid_busy", busy[0], 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk1("rst_mid_no_valid", out_valid[0], 1'b0);
        end
        run_one(0, V29_IN, V29_OUT);

        // back-to-back with in_valid held high
        for (int k = 0; k < 2; k++) begin
            acc_q0.delete();
            acc_q1.delete();
            @(posedge clk);
            #2;
            din[k]      = V30_IN;
            in_valid[k] = 1'b1;
            repeat ((k == 0) ? 22 : 10) begin
                @(posedge clk);
                #2;
                din[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            in_valid[k] = 1'b0;
            repeat (8) @(posedge clk);
            sz = (k == 0) ? acc_q0.size() : acc_q1.size();
            chk1($sformatf("b2b_count[%0d]", k), sz >= 3, 1'b1);
            for (int i = 1; i < sz; i++) begin
                if (k == 0)
                    chk("b2b_gap[0]", 128'(acc_q0[i] - acc_q0[i-1]), 128'd5);
                else
                    chk("b2b_gap[1]", 128'(acc_q1[i] - acc_q1[i-1]), 128'd2);
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/inv_shift_rows_seq.md
INV_SHIFT_ROWS_SEQ -- requirements
Module: inv_shift_rows_seq

Interface
REQ-001 The module SHALL have parameter ROW_SERIAL, default 1: 1 processes one state row per cycle, 0 processes all rows in one cycle.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: Input holds a block to accept.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block can accept Input this cycle.
REQ-006 The module SHALL have port Input, input, 128 bits: ciphertext-side AES state to un-shift.
REQ-007 The module SHALL have port out_valid, output, 1 bit: Output holds a finished block.
REQ-008 The module SHALL have port out_ready, input, 1 bit: the consumer takes Output this cycle.
REQ-009 The module SHALL have port Output, output, 128 bits: inverse-shift-rows result, driven from the internal data register.
REQ-010 The module SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-011 Byte layout SHALL be column-major: byte i occupies bits [127-8i : 120-8i], with row r = i mod 4 and column c = i div 4.
REQ-012 Transform SHALL be out[r][c] = in[r][(c - r) mod 4], i.e. row r rotates right by r columns; row 0 is unchanged.
REQ-013 FSM states SHALL be IDLE, ROW1, ROW2, ROW3, DONE.
REQ-014 In IDLE: in_ready = 1 (0 while rst = 1); out_valid = 0.
REQ-015 Accept SHALL occur on a rising edge with in_valid && in_ready; Input is captured into the data register.
REQ-016 With ROW_SERIAL=1, accept SHALL go to ROW1; ROW1, ROW2 and ROW3 each apply the rotation for their own row to the register in one cycle, then advance in order to ROW2, ROW3, DONE.
REQ-017 With ROW_SERIAL=0, accept SHALL load the fully transformed Input and go directly to DONE.
REQ-018 Latency SHALL be: out_valid high in the 4th cycle after the accepting edge (serial), or the 1st cycle after it (parallel).
REQ-019 In DONE: out_valid = 1; Output and out_valid SHALL hold stable while out_ready = 0; on an edge with out_ready = 1, go to IDLE.
REQ-020 in_ready SHALL be 0 in every state other than IDLE; in_valid is ignored there and Input changes have no effect.
REQ-021 No overlap SHALL occur: DONE with out_ready = 1 does not accept in the same cycle; peak throughput is 1 block per 5 cycles (serial) or 2 cycles (parallel).
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 The data register SHALL hold its value in IDLE; Output in IDLE shows the last result (zero after reset).

Reset
REQ-025 With rst = 1 at a rising edge, the next state SHALL be state = IDLE, data register = 0, out_valid = 0, busy = 0.
REQ-026 While rst = 1, in_ready SHALL be 0.
REQ-027 Reset mid-operation (ROW1..ROW3 or DONE) SHALL abandon the block; no out_valid pulse follows.
REQ-028 The first accept after reset SHALL be possible on the first edge with rst = 0 and in_valid = 1.

Verification
REQ-029 Input d4bf5d30e0b452aeb84111f11e2798e5, ROW_SERIAL=1, out_ready=1 -> Output d42711aee0bf98f1b8b45de51e415230 with out_valid in the 4th cycle after accept, high for 1 cycle.
REQ-030 Input 000102030405060708090a0b0c0d0e0f, ROW_SERIAL=0 -> Output 000d0a0704010e0b0805020f0c090603 with out_valid in the 1st cycle after accept.
REQ-031 Input 00112233 repeated 4 times, either parameter value -> Output identical to Input.
REQ-032 Backpressure case: hold out_ready = 0 for 10 cycles in DONE, toggle in_valid/Input meanwhile -> Output, out_valid = 1 and in_ready = 0 stay stable; on out_ready = 1, IDLE and in_ready = 1 next cycle.
REQ-033 Reset case: assert rst for 1 cycle while in ROW2 -> IDLE, Output = 0, no out_valid; then a new accept completes normally with the correct result.
REQ-034 Back-to-back case: in_valid held high with out_ready = 1 -> accepts spaced exactly 5 cycles (serial) or 2 cycles (parallel); all results correct.
